// File: rtl/spi_pkg.sv
// Shared defaults and entry-width constant for the SPI byte-to-word FIFO.
package spi_pkg;
  localparam int SPI_DATA_W         = 8;
  localparam int SPI_BYTES_PER_WORD = 2;
  localparam int SPI_DEPTH          = 160;
  // One FIFO entry: mode flag on top of the packed word.
  localparam int SPI_ENTRY_W        = 1 + SPI_BYTES_PER_WORD * SPI_DATA_W;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO storage with explicit modulo-DEPTH pointers and an
// occupancy counter; flush clears everything and wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = spi_pkg::SPI_ENTRY_W,
  parameter int DEPTH = spi_pkg::SPI_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // Non-power-of-two depth: wrap by compare, not by overflow.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rptr_q];

  // Next pointers and count; a push+pop pair leaves the count alone.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_next(wptr_q);
      if (do_pop)  rptr_d = ptr_next(rptr_q);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/spi_word_fifo.sv
// Packs SPI bytes MSB-first into RAM words, passes mode bytes through as
// single entries, and queues both in a sync_fifo for the RAM side.
module spi_word_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W         = SPI_DATA_W,
  parameter int BYTES_PER_WORD = SPI_BYTES_PER_WORD,
  parameter int DEPTH          = SPI_DEPTH,
  localparam int WORD_W        = BYTES_PER_WORD * DATA_W,
  localparam int LVL_W         = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [DATA_W:0]   Data,
  input  logic              i_SPI_valid,
  output logic              o_SPI_ready,
  input  logic              i_flush,
  output logic [WORD_W-1:0] Data_RAM,
  output logic              Mode,
  output logic              o_RAM_valid,
  input  logic              i_RAM_ready,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_frag_drop
);
  localparam int ENTRY_W = 1 + WORD_W;
  localparam int CNT_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

  logic [BYTES_PER_WORD-1:0][DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frag_q, frag_d;
  logic               accept, fifo_push, mode_in;
  logic [DATA_W-1:0]  byte_in;
  logic [ENTRY_W-1:0] entry, head;

  assign mode_in     = Data[DATA_W];
  assign byte_in     = Data[DATA_W-1:0];
  assign accept      = i_SPI_valid && o_SPI_ready;
  assign o_SPI_ready = !o_full;
  assign o_RAM_valid = !o_empty;
  assign o_frag_drop = frag_q;
  assign Data_RAM    = head[WORD_W-1:0];
  assign Mode        = head[WORD_W];

  // Packer: byte n of a word lands in lane BYTES_PER_WORD-1-n; the final
  // byte pushes the whole word, a mode byte pushes alone and drops any
  // partial word.
  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    frag_d    = 1'b0;
    fifo_push = 1'b0;
    entry     = {1'b0, word_q};
    if (i_flush) begin
      cnt_d = '0;
    end else if (accept) begin
      if (mode_in) begin
        fifo_push = 1'b1;
        frag_d    = (cnt_q != '0);
        cnt_d     = '0;
        entry     = {1'b1, WORD_W'(byte_in) << (WORD_W - DATA_W)};
      end else begin
        for (int i = 0; i < BYTES_PER_WORD; i++)
          if (CNT_W'(BYTES_PER_WORD - 1 - i) == cnt_q) word_d[i] = byte_in;
        if (cnt_q == LAST) begin
          fifo_push = 1'b1;
          cnt_d     = '0;
          entry     = {1'b0, word_d};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Packer state and the registered fragment-drop pulse.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      word_q <= '0;
      cnt_q  <= '0;
      frag_q <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      frag_q <= frag_d;
    end
  end

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_n),
    .flush (i_flush),
    .push  (fifo_push),
    .wdata (entry),
    .pop   (i_RAM_ready),
    .rdata (head),
    .level (o_level),
    .full  (o_full),
    .empty (o_empty)
  );
endmodule
